// File: rtl/layer_argmax_sel_if.sv
// Handshake bundle between the last FC layer, the argmax selector and the
// downstream consumer of the winning class.
interface layer_argmax_sel_if #(
    parameter int NUM_IN = 16,
    parameter int DW     = 8,
    parameter int IDX_W  = 5
);
    logic [NUM_IN*DW-1:0] in_vec;
    logic                 in_valid;
    logic                 in_ready;
    logic [IDX_W-1:0]     out_idx;
    logic [DW-1:0]        out_max;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_idx, out_max, out_valid
    );

    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_idx, out_max, out_valid
    );
endinterface

// File: rtl/layer_argmax_sel.sv
// Captures one layer of unsigned node scores, scans them one per cycle and
// presents the index/score of the largest (lowest index wins ties).
//
// state | meaning
// IDLE  | waiting for a layer result, in_ready high
// SCAN  | comparing buffered node cnt against running best
// HOLD  | result presented with out_valid, waiting for out_ready
module layer_argmax_sel #(
    parameter int NUM_IN = 16,
    parameter int DW     = 8,
    parameter int IDX_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    layer_argmax_sel_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_IN - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     best_q, best_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [DW-1:0]     out_max_q, out_max_d;
    logic [DW-1:0]     nodes_q [NUM_IN];
    logic [DW-1:0]     cand;
    logic              capture;

    always_comb begin
        cand = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (cnt_q == IDX_W'(k)) cand = nodes_q[k];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        out_idx_d  = out_idx_q;
        out_max_d  = out_max_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    capture    = 1'b1;
                    best_d     = bus.in_vec[DW-1:0];
                    best_idx_d = '0;
                    cnt_d      = IDX_W'(1);
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // strict compare keeps the earlier index on ties
                if (cand > best_q) begin
                    best_d     = cand;
                    best_idx_d = cnt_q;
                end
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST) begin
                    out_idx_d = best_idx_d;
                    out_max_d = best_d;
                    cnt_d     = '0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            out_idx_q  <= '0;
            out_max_q  <= '0;
            for (int k = 0; k < NUM_IN; k++) nodes_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            out_idx_q  <= out_idx_d;
            out_max_q  <= out_max_d;
            if (capture) begin
                for (int k = 0; k < NUM_IN; k++) nodes_q[k] <= bus.in_vec[k*DW +: DW];
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_idx   = out_idx_q;
    assign bus.out_max   = out_max_q;

endmodule

// File: tb/tb_layer_argmax_sel.sv
// Directed bench for layer_argmax_sel: timestamp-based reference model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_layer_argmax_sel;
    localparam int NUM_IN = 16;
    localparam int DW     = 8;
    localparam int IDX_W  = 5;
    localparam int W      = NUM_IN * DW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    layer_argmax_sel_if #(.NUM_IN(NUM_IN), .DW(DW), .IDX_W(IDX_W)) bus ();

    layer_argmax_sel #(.NUM_IN(NUM_IN), .DW(DW), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void argmax(input logic [W-1:0] v, output int idx, output int mx);
        idx = 0;
        mx  = int'(v[DW-1:0]);
        for (int k = 1; k < NUM_IN; k++) begin
            if (int'(v[k*DW +: DW]) > mx) begin
                mx  = int'(v[k*DW +: DW]);
                idx = k;
            end
        end
    endfunction

    function automatic logic [W-1:0] mkvec(input int fill);
        logic [W-1:0] v;
        for (int k = 0; k < NUM_IN; k++) v[k*DW +: DW] = DW'(fill);
        return v;
    endfunction

    // Reference model: a result is owed NUM_IN-1 edges after acceptance and
    // stays owed until it is handed over or reset drops it.
    int cyc     = 0;
    bit started = 1'b0;
    bit m_busy  = 1'b0;
    int m_rdy   = 0;
    int m_idx   = 0;
    int m_max   = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_busy  = 1'b0;
            started = 1'b1;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy = 1'b1;
                argmax(bus.in_vec, m_idx, m_max);
                m_rdy = cyc + NUM_IN - 1;
            end
        end else if ((cyc - 1) >= m_rdy && bus.out_ready) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_in_ready", int'(bus.in_ready), int'(!m_busy && !reset));
            check("model_out_valid", int'(bus.out_valid), int'(m_busy && cyc >= m_rdy));
            if (m_busy && cyc >= m_rdy) begin
                check("model_out_idx", int'(bus.out_idx), m_idx);
                check("model_out_max", int'(bus.out_max), m_max);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Returns edges from acceptance until out_valid is seen (bounded).
    task automatic wait_valid(input bit scramble, output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            if (scramble) bus.in_vec = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            n++;
        end
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] v,
                           input int e_idx, input int e_max, input bit scramble);
        int n;
        bus.in_vec    = v;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        wait_valid(scramble, n);
        check({name, "_latency"}, n, 15);
        check({name, "_idx"}, int'(bus.out_idx), e_idx);
        check({name, "_max"}, int'(bus.out_max), e_max);
        cycle();
        check({name, "_in_ready_after"}, int'(bus.in_ready), 1);
        check({name, "_valid_dropped"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        logic [W-1:0] v;
        int n;
        bus.in_vec    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) cycle();
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_idx", int'(bus.out_idx), 0);
        check("rst_out_max", int'(bus.out_max), 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        cycle();

        v = mkvec(10); v[5*DW +: DW] = 8'd200;
        run_vec("basic", v, 5, 200, 1'b0);

        v = mkvec(50); v[3*DW +: DW] = 8'd127; v[9*DW +: DW] = 8'd127;
        run_vec("tie", v, 3, 127, 1'b0);

        run_vec("zeros", mkvec(0), 0, 0, 1'b0);

        v = mkvec(0); v[15*DW +: DW] = 8'd1;
        run_vec("last", v, 15, 1, 1'b0);

        v = mkvec(255);
        run_vec("all_max", v, 0, 255, 1'b0);

        // backpressure with a second request pending
        v = mkvec(1); v[7*DW +: DW] = 8'd77;
        bus.in_vec = v; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        cycle();
        bus.in_valid = 1'b0;
        wait_valid(1'b0, n);
        check("bp_first_latency", n, 15);
        v = mkvec(0); v[2*DW +: DW] = 8'd99;
        bus.in_vec = v; bus.in_valid = 1'b1;
        repeat (20) begin
            cycle();
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_hold_valid", int'(bus.out_valid), 1);
            check("bp_hold_idx", int'(bus.out_idx), 7);
            check("bp_hold_max", int'(bus.out_max), 77);
        end
        bus.out_ready = 1'b1;
        cycle();
        check("bp_release_in_ready", int'(bus.in_ready), 1);
        cycle();
        bus.in_valid = 1'b0;
        wait_valid(1'b0, n);
        check("bp_second_latency", n, 15);
        check("bp_second_idx", int'(bus.out_idx), 2);
        check("bp_second_max", int'(bus.out_max), 99);
        cycle();

        // reset in the middle of a scan drops the result
        v = mkvec(3); v[4*DW +: DW] = 8'd44;
        bus.in_vec = v; bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        n = 0;
        repeat (20) begin
            cycle();
            if (bus.out_valid) n++;
        end
        check("abort_never_valid", n, 0);
        v = mkvec(249); v[12*DW +: DW] = 8'd250;
        run_vec("after_abort", v, 12, 250, 1'b0);

        // upstream keeps changing in_vec while the scan runs
        v = mkvec(5); v[11*DW +: DW] = 8'd222;
        run_vec("scramble", v, 11, 222, 1'b1);

        repeat (3) cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
